key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event.sv | 149 ++++++++++++++
 tb/tb_key_event.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// key_event: turns a debounced, active-low key level into event pulses.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   key_i     debounced key level, 0 = pressed, synchronous to clk
//   press_p   one-cycle pulse on press
//   click_p   one-cycle pulse on release of a short press
//   long_p    one-cycle pulse when the hold reaches LONG_MS ticks
//   rpt_p     one-cycle auto-repeat pulse while long-held
//   release_p one-cycle pulse on any release
//   held      level, 1 from the press_p cycle through the release_p cycle
//
// state | meaning
// IDLE  | key up, waiting for a press edge
// HELD  | key down, hold shorter than LONG_MS ticks
// LONG  | key down, long press issued, auto-repeat running
module key_event #(
   parameter int TICK_CYC = 50000,
   parameter int LONG_MS  = 1000,
   parameter int RPT_MS   = 200,
   parameter bit RPT_EN   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_p,
   output logic click_p,
   output logic long_p,
   output logic rpt_p,
   output logic release_p,
   output logic held
);

   localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int HW = (LONG_MS > 1) ? $clog2(LONG_MS) : 1;
   localparam int RW = (RPT_MS > 1) ? $clog2(RPT_MS) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYC - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS - 1);
   localparam logic [RW-1:0] RPT_MAX   = RW'(RPT_MS - 1);

   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

   state_t        state, state_n;
   logic          k_d;
   logic [PW-1:0] presc, presc_n;
   logic [HW-1:0] hold, hold_n;
   logic [RW-1:0] rpt, rpt_n;
   logic          press_n, click_n, long_n, rpt_p_n, release_n, held_n;
   logic          press_e, rel_e, tick;

   assign press_e = k_d & ~key_i;
   assign rel_e   = ~k_d & key_i;
   assign tick    = (presc == PRESC_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         k_d       <= 1'b1;
         presc     <= '0;
         hold      <= '0;
         rpt       <= '0;
         press_p   <= 1'b0;
         click_p   <= 1'b0;
         long_p    <= 1'b0;
         rpt_p     <= 1'b0;
         release_p <= 1'b0;
         held      <= 1'b0;
      end else begin
         state     <= state_n;
         k_d       <= key_i;
         presc     <= presc_n;
         hold      <= hold_n;
         rpt       <= rpt_n;
         press_p   <= press_n;
         click_p   <= click_n;
         long_p    <= long_n;
         rpt_p     <= rpt_p_n;
         release_p <= release_n;
         held      <= held_n;
      end
   end

   always_comb begin
      state_n   = state;
      presc_n   = tick ? '0 : presc + 1'b1;
      hold_n    = hold;
      rpt_n     = rpt;
      press_n   = 1'b0;
      click_n   = 1'b0;
      long_n    = 1'b0;
      rpt_p_n   = 1'b0;
      release_n = 1'b0;

      case (state)
         IDLE: begin
            presc_n = '0;
            hold_n  = '0;
            rpt_n   = '0;
            if (press_e) begin
               state_n = HELD;
               press_n = 1'b1;
            end
         end
         HELD: begin
            // release wins over a long event landing on the same edge
            if (rel_e) begin
               state_n   = IDLE;
               presc_n   = '0;
               click_n   = 1'b1;
               release_n = 1'b1;
            end else if (tick) begin
               if (hold == HOLD_MAX) begin
                  state_n = LONG;
                  long_n  = 1'b1;
                  rpt_n   = '0;
               end else begin
                  hold_n = hold + 1'b1;
               end
            end
         end
         LONG: begin
            if (rel_e) begin
               state_n   = IDLE;
               presc_n   = '0;
               release_n = 1'b1;
            end else if (tick) begin
               if (rpt == RPT_MAX) begin
                  // with repeat disabled the counter just parks at its max
                  if (RPT_EN) begin
                     rpt_p_n = 1'b1;
                     rpt_n   = '0;
                  end
               end else begin
                  rpt_n = rpt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // held spans the release_p cycle as well
      held_n = (state_n != IDLE) | release_n;
   end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with TICK_CYC=4, LONG_MS=5, RPT_MS=3.
// u_dut has auto-repeat enabled, u_dut_nr has it disabled; both see the
// same key and reset.
module tb_key_event;

   logic clk = 1'b0;
   logic rst_n;
   logic key_i;

   logic press_p, click_p, long_p, rpt_p, release_p, held;
   logic press_p0, click_p0, long_p0, rpt_p0, release_p0, held0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   key_event #(.TICK_CYC(4), .LONG_MS(5), .RPT_MS(3), .RPT_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .key_i(key_i),
      .press_p(press_p), .click_p(click_p), .long_p(long_p),
      .rpt_p(rpt_p), .release_p(release_p), .held(held)
   );

   key_event #(.TICK_CYC(4), .LONG_MS(5), .RPT_MS(3), .RPT_EN(1'b0)) u_dut_nr (
      .clk(clk), .rst_n(rst_n), .key_i(key_i),
      .press_p(press_p0), .click_p(click_p0), .long_p(long_p0),
      .rpt_p(rpt_p0), .release_p(release_p0), .held(held0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // event log, sampled mid-cycle
   int press_n = 0, click_n = 0, long_n = 0, rpt_n = 0, rel_n = 0;
   int press_t[64], click_t[64], long_t[64], rpt_t[64], rel_t[64];
   int held_cyc = 0, multi = 0;
   int long0_n = 0, rpt0_n = 0, rel0_n = 0;

   always @(negedge clk) begin
      if (press_p) begin
         if (press_n < 64) press_t[press_n] = cyc;
         press_n++;
      end
      if (click_p) begin
         if (click_n < 64) click_t[click_n] = cyc;
         click_n++;
      end
      if (long_p) begin
         if (long_n < 64) long_t[long_n] = cyc;
         long_n++;
      end
      if (rpt_p) begin
         if (rpt_n < 64) rpt_t[rpt_n] = cyc;
         rpt_n++;
      end
      if (release_p) begin
         if (rel_n < 64) rel_t[rel_n] = cyc;
         rel_n++;
      end
      if (held) held_cyc++;
      if (int'(press_p) + int'(long_p) + int'(rpt_p) > 1) multi++;
      if (long_p0) long0_n++;
      if (rpt_p0) rpt0_n++;
      if (release_p0) rel0_n++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // key low for n sampling edges, then high again
   task automatic hold_low(input int n);
      @(posedge clk) #1 key_i = 1'b0;
      repeat (n) @(posedge clk);
      #1 key_i = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   int sp, sc, sl, sr, srel, sh, sl0, sr0, srel0, rcyc;

   task automatic snap();
      sp = press_n; sc = click_n; sl = long_n; sr = rpt_n; srel = rel_n;
      sh = held_cyc; sl0 = long0_n; sr0 = rpt0_n; srel0 = rel0_n;
   endtask

   initial begin
      rst_n = 1'b0;
      key_i = 1'b1;
      idle(3);
      @(negedge clk);
      check("reset_outputs", {press_p, click_p, long_p, rpt_p, release_p, held}, 0);
      check("reset_outputs_nr", {press_p0, click_p0, long_p0, rpt_p0, release_p0, held0}, 0);
      @(posedge clk) #1 rst_n = 1'b1;
      idle(3);

      // short press: 8 low samples
      snap();
      hold_low(8);
      idle(5);
      check("short_press_cnt", press_n - sp, 1);
      check("short_click_cnt", click_n - sc, 1);
      check("short_release_cnt", rel_n - srel, 1);
      check("short_long_cnt", long_n - sl, 0);
      check("short_held_cycles", held_cyc - sh, 9);
      check("short_click_delay", click_t[sc] - press_t[sp], 8);
      check("short_release_delay", rel_t[srel] - press_t[sp], 8);

      // long press with repeats: 60 low samples
      snap();
      hold_low(60);
      idle(5);
      check("long_cnt", long_n - sl, 1);
      check("long_delay", long_t[sl] - press_t[sp], 20);
      check("rpt_cnt", rpt_n - sr, 3);
      check("rpt1_delay", rpt_t[sr] - long_t[sl], 12);
      check("rpt2_delay", rpt_t[sr + 1] - long_t[sl], 24);
      check("rpt3_delay", rpt_t[sr + 2] - long_t[sl], 36);
      check("long_click_cnt", click_n - sc, 0);
      check("long_release_cnt", rel_n - srel, 1);
      check("long_release_delay", rel_t[srel] - press_t[sp], 60);
      check("nr_long_cnt", long0_n - sl0, 1);
      check("nr_rpt_cnt", rpt0_n - sr0, 0);
      check("nr_release_cnt", rel0_n - srel0, 1);

      // release on the exact long boundary: 20 low samples
      snap();
      hold_low(20);
      idle(5);
      check("edge_long_cnt", long_n - sl, 0);
      check("edge_click_cnt", click_n - sc, 1);
      check("edge_release_cnt", rel_n - srel, 1);
      check("edge_click_delay", click_t[sc] - press_t[sp], 20);

      // reset asserted while in LONG, key kept low across reset
      snap();
      @(posedge clk) #1 key_i = 1'b0;
      idle(25);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {press_p, click_p, long_p, rpt_p, release_p, held}, 0);
      idle(3);
      #1 rst_n = 1'b1;
      rcyc = cyc;
      idle(4);
      check("rst_mid_release_cnt", rel_n - srel, 0);
      check("rst_mid_click_cnt", click_n - sc, 0);
      check("rst_repress_cnt", press_n - sp, 2);
      check("rst_repress_time", press_t[sp + 1], rcyc + 1);
      #1 key_i = 1'b1;
      idle(5);
      check("rst_after_release_cnt", rel_n - srel, 1);

      // back-to-back presses with a single high sample between them;
      // 18+18 samples would reach LONG only if the hold count did not restart
      snap();
      @(posedge clk) #1 key_i = 1'b0;
      idle(18);
      #1 key_i = 1'b1;
      @(posedge clk) #1 key_i = 1'b0;
      idle(18);
      #1 key_i = 1'b1;
      idle(5);
      check("b2b_press_cnt", press_n - sp, 2);
      check("b2b_click_cnt", click_n - sc, 2);
      check("b2b_long_cnt", long_n - sl, 0);
      check("b2b_press_gap", press_t[sp + 1] - press_t[sp], 19);
      check("b2b_click2_delay", click_t[sc + 1] - press_t[sp + 1], 18);

      check("pulse_exclusive", multi, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
